alu_ctrl_md: RTL and testbench

//  Next-generation ALU control for the MIPS CPU. Decodes ALUOp/Funct into a 4-bit ALUControl and

---
 rtl/alu_ctrl_md.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_ctrl_md.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_md.sv
// EX-stage ALU control decode plus an iterative WIDTH-bit multiply/divide unit owning HI/LO.
// Optional build macro ALUCTL_MUL_EARLY_EN: multiplies finish once the remaining multiplier bits are zero.
module alu_ctrl_md #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [3:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       ALUControl,
  output logic             illegal,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             md_busy,
  output logic             stall
);

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_NOR  = 4'b0011;
  localparam logic [3:0] CTL_XOR  = 4'b0100;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_SLTU = 4'b1000;
  localparam logic [3:0] CTL_SLL  = 4'b1001;
  localparam logic [3:0] CTL_SRL  = 4'b1010;
  localparam logic [3:0] CTL_SRA  = 4'b1011;
  localparam logic [3:0] CTL_HILO = 4'b1100;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_RTYPE = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return (is_signed && sv[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic [1:0]         state;
  logic [CNTW-1:0]    cnt;
  logic [WIDTH-1:0]   hi, lo;

  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem, quo, divisor, a_raw;
  logic               neg_q, neg_r, div0;

  logic               is_rtype, op_mul, op_div, op_mthi, op_mtlo, op_mf, md_op, op_signed, idle;
  logic               start_mul, start_div, wr_hi, wr_lo;
  logic [WIDTH-1:0]   mag_a, mag_b;

  logic [2*WIDTH-1:0] acc_nxt, mul_res;
  logic [WIDTH-1:0]   mplier_nxt;
  logic               mul_done;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt, div_hi, div_lo;
  logic               div_done;

  always_comb begin
    ALUControl = CTL_ADD;
    illegal    = 1'b0;
    case (ALUOp)
      OP_ADD:  ALUControl = CTL_ADD;
      OP_SUB:  ALUControl = CTL_SUB;
      OP_AND:  ALUControl = CTL_AND;
      OP_OR:   ALUControl = CTL_OR;
      OP_XOR:  ALUControl = CTL_XOR;
      OP_SLT:  ALUControl = CTL_SLT;
      OP_SLTU: ALUControl = CTL_SLTU;
      OP_RTYPE: begin
        case (Funct)
          6'b100000, 6'b100001: ALUControl = CTL_ADD;
          6'b100010, 6'b100011: ALUControl = CTL_SUB;
          6'b100100:            ALUControl = CTL_AND;
          6'b100101:            ALUControl = CTL_OR;
          6'b100110:            ALUControl = CTL_XOR;
          6'b100111:            ALUControl = CTL_NOR;
          6'b101010:            ALUControl = CTL_SLT;
          6'b101011:            ALUControl = CTL_SLTU;
          6'b000000:            ALUControl = CTL_SLL;
          6'b000010:            ALUControl = CTL_SRL;
          6'b000011:            ALUControl = CTL_SRA;
          F_MFHI, F_MFLO:       ALUControl = CTL_HILO;
          F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO: ALUControl = CTL_ADD;
          default: begin
            ALUControl = CTL_ADD;
            illegal    = 1'b1;
          end
        endcase
      end
      default: ALUControl = CTL_ADD;
    endcase
  end

  assign is_rtype  = (ALUOp == OP_RTYPE);
  assign op_mul    = is_rtype && (Funct == F_MULT || Funct == F_MULTU);
  assign op_div    = is_rtype && (Funct == F_DIV  || Funct == F_DIVU);
  assign op_mthi   = is_rtype && (Funct == F_MTHI);
  assign op_mtlo   = is_rtype && (Funct == F_MTLO);
  assign op_mf     = is_rtype && (Funct == F_MFHI || Funct == F_MFLO);
  assign md_op     = op_mul || op_div || op_mthi || op_mtlo || op_mf;
  assign op_signed = ~Funct[0];

  assign idle      = (state == S_IDLE);
  assign md_busy   = ~idle;
  assign stall     = valid_in && md_op && md_busy;
  assign start_mul = valid_in && op_mul && idle;
  assign start_div = valid_in && op_div && idle;
  assign wr_hi     = valid_in && op_mthi && idle;
  assign wr_lo     = valid_in && op_mtlo && idle;

  assign hilo_rdata = (is_rtype && Funct == F_MFHI) ? hi : lo;

  assign mag_a = magnitude(a, op_signed);
  assign mag_b = magnitude(b, op_signed);

  // Shift-add multiply: one multiplier bit retired per cycle.
  assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
  assign mplier_nxt = mplier >> 1;
  assign mul_res    = neg_2w(acc_nxt, neg_q);

`ifdef ALUCTL_MUL_EARLY_EN
  assign mul_done = (mplier_nxt == '0);
`else
  assign mul_done = (cnt == LAST_ITER);
`endif

  // Restoring divide: the dividend shifts out of quo into rem one bit per cycle.
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, divisor};
  assign rem_nxt   = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign quo_nxt   = {quo[WIDTH-2:0], ~div_diff[WIDTH]};
  assign div_done  = (cnt == LAST_ITER);

  // Divide-by-zero returns the raw dividend in HI regardless of signedness.
  assign div_hi = div0 ? a_raw : neg_w(rem_nxt, neg_r);
  assign div_lo = div0 ? '1    : neg_w(quo_nxt, neg_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start_mul)      state <= S_MUL;
          else if (start_div) state <= S_DIV;
          if (wr_hi) hi <= a;
          if (wr_lo) lo <= a;
        end
        S_MUL: begin
          cnt <= cnt + CNTW'(1);
          if (mul_done) begin
            hi    <= mul_res[2*WIDTH-1:WIDTH];
            lo    <= mul_res[WIDTH-1:0];
            state <= S_IDLE;
          end
        end
        S_DIV: begin
          cnt <= cnt + CNTW'(1);
          if (div_done) begin
            hi    <= div_hi;
            lo    <= div_lo;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start_mul || start_div) begin
      mcand   <= {{WIDTH{1'b0}}, mag_a};
      mplier  <= mag_b;
      acc     <= '0;
      quo     <= mag_a;
      divisor <= mag_b;
      rem     <= '0;
      neg_q   <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r   <= op_signed && a[WIDTH-1];
      div0    <= (b == '0);
      a_raw   <= a;
    end else if (state == S_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier_nxt;
    end else if (state == S_DIV) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed self-checking bench for alu_ctrl_md at WIDTH=32 (decode, mult/div, HI/LO moves, stalls, reset).
module tb_alu_ctrl_md;
  localparam int W = 32;
`ifdef ALUCTL_MUL_EARLY_EN
  localparam int LAT_B7 = 3;
  localparam int LAT_B6 = 3;
  localparam int LAT_B1 = 1;
`else
  localparam int LAT_B7 = 32;
  localparam int LAT_B6 = 32;
  localparam int LAT_B1 = 32;
`endif
  localparam logic [3:0] OP_R    = 4'b0010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [3:0]   ALUOp;
  logic [5:0]   Funct;
  logic [W-1:0] a, b;
  logic [3:0]   ALUControl;
  logic         illegal;
  logic [W-1:0] hilo_rdata;
  logic         md_busy;
  logic         stall;

  int tests_run = 0;
  int tests_failed = 0;

  alu_ctrl_md #(.WIDTH(W), .CNTW(6)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ALUOp(ALUOp), .Funct(Funct),
    .a(a), .b(b), .ALUControl(ALUControl), .illegal(illegal),
    .hilo_rdata(hilo_rdata), .md_busy(md_busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] fn,
                       input logic [W-1:0] aa, input logic [W-1:0] bb);
    valid_in = v; ALUOp = op; Funct = fn; a = aa; b = bb;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
    drive(1'b0, OP_R, FN_MFHI, '0, '0);
    #1 h = hilo_rdata;
    Funct = FN_MFLO;
    #1 l = hilo_rdata;
  endtask

  // Issues one mult/div, then counts cycles until md_busy falls (bounded).
  task automatic run_md(input logic [5:0] fn, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        output int busy);
    drive(1'b1, OP_R, fn, aa, bb);
    tick();
    drive(1'b0, OP_R, 6'b100000, '0, '0);
    busy = 0;
    while (md_busy && busy < 200) begin
      tick();
      busy++;
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] h, l;
    rst = 1'b1;
    drive(1'b0, OP_R, 6'b100000, '0, '0);
    repeat (2) tick();
    tests_run++;
    if (md_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", md_busy); end
    read_hilo(h, l);
    tests_run++;
    if (h !== 32'h0) begin tests_failed++; $display("FAIL reset_hi got %h want 0", h); end
    tests_run++;
    if (l !== 32'h0) begin tests_failed++; $display("FAIL reset_lo got %h want 0", l); end
    drive(1'b1, OP_R, FN_MULT, 32'd1, 32'd1);
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b want 0", stall); end
    drive(1'b0, OP_R, 6'b100000, '0, '0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_decode();
    logic [5:0] fns [21];
    logic [3:0] exps [21];
    logic [3:0] ops [8];
    logic [3:0] opexp [8];
    fns  = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
             6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b010000,
             6'b010010, 6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010001, 6'b010011};
    exps = '{4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0000, 4'b0001, 4'b0100,
             4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100,
             4'b1100, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    ops   = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1111};
    opexp = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0100, 4'b0111, 4'b1000, 4'b0010};
    for (int i = 0; i < 21; i++) begin
      drive(1'b0, OP_R, fns[i], '0, '0);
      #1;
      tests_run++;
      if (ALUControl !== exps[i] || illegal !== 1'b0) begin
        tests_failed++;
        $display("FAIL decode_funct %b got ctl=%b ill=%b want ctl=%b ill=0", fns[i], ALUControl, illegal, exps[i]);
      end
    end
    drive(1'b0, OP_R, 6'b111111, '0, '0);
    #1;
    tests_run++;
    if (ALUControl !== 4'b0010 || illegal !== 1'b1) begin
      tests_failed++;
      $display("FAIL decode_illegal got ctl=%b ill=%b want ctl=0010 ill=1", ALUControl, illegal);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, ops[i], 6'b111111, '0, '0);
      #1;
      tests_run++;
      if (ALUControl !== opexp[i] || illegal !== 1'b0) begin
        tests_failed++;
        $display("FAIL decode_aluop %b got ctl=%b ill=%b want ctl=%b ill=0", ops[i], ALUControl, illegal, opexp[i]);
      end
    end
  endtask

  task automatic test_mult();
    logic [W-1:0] h, l;
    int busy;
    drive(1'b1, OP_R, FN_MULT, 32'hFFFFFFFD, 32'd7);
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL mult_start_stall got %b want 0", stall); end
    tick();
    tests_run++;
    if (md_busy !== 1'b1) begin tests_failed++; $display("FAIL mult_busy_rise got %b want 1", md_busy); end
    drive(1'b0, OP_R, 6'b100000, '0, '0);
    busy = 1;
    while (md_busy && busy < 200) begin tick(); if (md_busy) busy++; end
    tests_run++;
    if (busy !== LAT_B7) begin tests_failed++; $display("FAIL mult_latency got %0d want %0d", busy, LAT_B7); end
    read_hilo(h, l);
    tests_run++;
    if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFEB) begin
      tests_failed++; $display("FAIL mult_neg got hi=%h lo=%h want FFFFFFFF FFFFFFEB", h, l);
    end
    run_md(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, busy);
    read_hilo(h, l);
    tests_run++;
    if (busy !== 32 || h !== 32'hFFFFFFFE || l !== 32'h00000001) begin
      tests_failed++; $display("FAIL multu_max got busy=%0d hi=%h lo=%h want 32 FFFFFFFE 00000001", busy, h, l);
    end
    run_md(FN_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, busy);
    read_hilo(h, l);
    tests_run++;
    if (busy !== LAT_B1 || h !== 32'h0 || l !== 32'h1) begin
      tests_failed++; $display("FAIL mult_m1m1 got busy=%0d hi=%h lo=%h want %0d 0 1", busy, h, l, LAT_B1);
    end
  endtask

  task automatic test_div();
    logic [W-1:0] h, l;
    int busy;
    run_md(FN_DIV, 32'hFFFFFFF9, 32'd2, busy);
    read_hilo(h, l);
    tests_run++;
    if (busy !== 32 || h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFD) begin
      tests_failed++; $display("FAIL div_m7_2 got busy=%0d hi=%h lo=%h want 32 FFFFFFFF FFFFFFFD", busy, h, l);
    end
    run_md(FN_DIV, 32'd100, 32'hFFFFFFF9, busy);
    read_hilo(h, l);
    tests_run++;
    if (h !== 32'd2 || l !== 32'hFFFFFFF2) begin
      tests_failed++; $display("FAIL div_100_m7 got hi=%h lo=%h want 00000002 FFFFFFF2", h, l);
    end
    run_md(FN_DIV, 32'h80000000, 32'hFFFFFFFF, busy);
    read_hilo(h, l);
    tests_run++;
    if (h !== 32'h0 || l !== 32'h80000000) begin
      tests_failed++; $display("FAIL div_min_m1 got hi=%h lo=%h want 00000000 80000000", h, l);
    end
    run_md(FN_DIVU, 32'd7, 32'd0, busy);
    read_hilo(h, l);
    tests_run++;
    if (busy !== 32 || h !== 32'd7 || l !== 32'hFFFFFFFF) begin
      tests_failed++; $display("FAIL divu_by0 got busy=%0d hi=%h lo=%h want 32 00000007 FFFFFFFF", busy, h, l);
    end
    run_md(FN_DIV, 32'hFFFFFFFB, 32'd0, busy);
    read_hilo(h, l);
    tests_run++;
    if (h !== 32'hFFFFFFFB || l !== 32'hFFFFFFFF) begin
      tests_failed++; $display("FAIL div_neg_by0 got hi=%h lo=%h want FFFFFFFB FFFFFFFF", h, l);
    end
  endtask

  task automatic test_collision();
    logic [W-1:0] h, l;
    int busy, stalls;
    drive(1'b1, OP_R, FN_MULT, 32'd5, 32'd6);
    tick();
    busy = 0;
    stalls = 0;
    while (md_busy && busy < 200) begin
      if (busy < 2) drive(1'b1, OP_R, FN_MULTU, 32'd9, 32'd9);
      else          drive(1'b1, OP_R, FN_MFLO, '0, '0);
      #1;
      if (stall) stalls++;
      tick();
      busy++;
    end
    tests_run++;
    if (busy !== LAT_B6 || stalls !== LAT_B6) begin
      tests_failed++; $display("FAIL collide_stall got busy=%0d stalls=%0d want %0d %0d", busy, stalls, LAT_B6, LAT_B6);
    end
    drive(1'b1, OP_R, FN_MFLO, '0, '0);
    #1;
    tests_run++;
    if (stall !== 1'b0 || hilo_rdata !== 32'd30) begin
      tests_failed++; $display("FAIL collide_mflo got stall=%b lo=%h want 0 0000001e", stall, hilo_rdata);
    end
    tick();
    drive(1'b0, OP_R, 6'b100000, '0, '0);
    tick();
    read_hilo(h, l);
    tests_run++;
    if (md_busy !== 1'b0 || h !== 32'h0 || l !== 32'd30) begin
      tests_failed++; $display("FAIL collide_dropped got busy=%b hi=%h lo=%h want 0 0 1e", md_busy, h, l);
    end
  endtask

  task automatic test_mthi();
    logic [W-1:0] h, l;
    int busy;
    drive(1'b1, OP_R, FN_MTHI, 32'h1234, '0);
    tick();
    drive(1'b1, OP_R, FN_MTLO, 32'hABCD, '0);
    tick();
    read_hilo(h, l);
    tests_run++;
    if (h !== 32'h1234 || l !== 32'hABCD) begin
      tests_failed++; $display("FAIL mthi_mtlo got hi=%h lo=%h want 00001234 0000abcd", h, l);
    end
    drive(1'b1, OP_R, FN_DIVU, 32'd100, 32'd7);
    tick();
    drive(1'b1, OP_R, FN_MTHI, 32'hDEAD, '0);
    #1;
    tests_run++;
    if (stall !== 1'b1) begin tests_failed++; $display("FAIL mthi_busy_stall got %b want 1", stall); end
    tick();
    read_hilo(h, l);
    tests_run++;
    if (h !== 32'h1234) begin tests_failed++; $display("FAIL mthi_busy_nowrite got hi=%h want 00001234", h); end
    drive(1'b1, 4'b0000, 6'b000000, 32'd1, 32'd2);
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL addi_busy_stall got %b want 0", stall); end
    drive(1'b1, OP_R, 6'b100000, 32'd1, 32'd2);
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL add_busy_stall got %b want 0", stall); end
    drive(1'b1, OP_R, FN_MFHI, '0, '0);
    #1;
    tests_run++;
    if (stall !== 1'b1) begin tests_failed++; $display("FAIL mfhi_busy_stall got %b want 1", stall); end
    drive(1'b0, OP_R, 6'b100000, '0, '0);
    busy = 0;
    while (md_busy && busy < 200) begin tick(); busy++; end
    read_hilo(h, l);
    tests_run++;
    if (busy !== 31 || h !== 32'd2 || l !== 32'd14) begin
      tests_failed++; $display("FAIL divu_100_7 got busy=%0d hi=%h lo=%h want 31 2 e", busy, h, l);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] h, l;
    int busy;
    drive(1'b1, OP_R, FN_MTHI, 32'h55, '0);
    tick();
    drive(1'b1, OP_R, FN_MTLO, 32'h66, '0);
    tick();
    drive(1'b1, OP_R, FN_DIV, 32'd100, 32'd3);
    tick();
    drive(1'b0, OP_R, 6'b100000, '0, '0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    read_hilo(h, l);
    tests_run++;
    if (md_busy !== 1'b0 || h !== 32'h0 || l !== 32'h0) begin
      tests_failed++; $display("FAIL reset_mid got busy=%b hi=%h lo=%h want 0 0 0", md_busy, h, l);
    end
    run_md(FN_MULT, 32'd6, 32'd7, busy);
    read_hilo(h, l);
    tests_run++;
    if (busy !== LAT_B7 || h !== 32'h0 || l !== 32'd42) begin
      tests_failed++; $display("FAIL reset_then_mult got busy=%0d hi=%h lo=%h want %0d 0 2a", busy, h, l, LAT_B7);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_div();
    test_collision();
    test_mthi();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
